// File: rtl/bus_pkg.sv
// Shared types and constants for the single-master bus interconnect.
// Optional slave timeout is enabled with BUS_TIMEOUT_EN.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [2:0] LEN_BYTE = 3'b000;
  localparam logic [2:0] LEN_HALF = 3'b001;
  localparam logic [2:0] LEN_WORD = 3'b010;

  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: top SEL_W address bits pick the slave,
// hit is low when the index is beyond the populated slave ports.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SEL_W      = 4,
  parameter int NUM_SLAVES = 4
) (
  input  logic [ADDR_W-1:0] address,
  output logic [SEL_W-1:0]  sel,
  output logic              hit
);

  logic unused_low_s;

  // Extract the select field and range-check it
  always_comb begin
    sel          = address[ADDR_W-1 -: SEL_W];
    hit          = (32'(sel) < 32'(NUM_SLAVES));
    unused_low_s = ^address[ADDR_W-SEL_W-1:0];
  end

endmodule

// File: rtl/bus_interconnect.sv
// Single-master to NUM_SLAVES interconnect with IDLE/ACCESS/RESP handshake.
// Define BUS_TIMEOUT_EN to bound ACCESS by TIMEOUT_CYC cycles.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic [ADDR_W-1:0]            m_address,
  input  logic [DATA_W-1:0]            m_wr_data,
  input  logic                         m_wr_enable,
  input  logic [2:0]                   m_write_length,
  output logic                         m_resp_valid,
  output logic [DATA_W-1:0]            m_read_data,
  output logic                         m_error,
  output logic [NUM_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]            s_address,
  output logic [DATA_W-1:0]            s_wr_data,
  output logic                         s_wr_enable,
  output logic [2:0]                   s_write_length,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_read_data
);

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [2:0]            len_q, len_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [SEL_W-1:0]      dec_sel_s;
  logic                  dec_hit_s;
  logic [NUM_SLAVES-1:0] sel_onehot_s;
  logic [DATA_W-1:0]     slice_s;
  logic                  done_s;

`ifdef BUS_TIMEOUT_EN
  logic [TMO_CNT_W-1:0]  tmo_q, tmo_d;
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
`endif

  bus_addr_decoder #(
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_dec (
    .address (m_address),
    .sel     (dec_sel_s),
    .hit     (dec_hit_s)
  );

  // One-hot request vector and read-data slice for the latched slave
  always_comb begin
    sel_onehot_s = '0;
    slice_s      = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_onehot_s[i] = (dec_sel_s == SEL_W'(i));
      slice_s        |= (sel_q == SEL_W'(i)) ? s_read_data[i*DATA_W +: DATA_W] : '0;
    end
    // s_valid_q is one-hot on sel, so this ignores every other slave's ready
    done_s = |(s_ready & s_valid_q);
  end

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    s_valid_d    = s_valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    len_d        = len_q;
    sel_d        = sel_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          addr_d  = m_address;
          wdata_d = m_wr_data;
          we_d    = m_wr_enable;
          len_d   = m_write_length;
          sel_d   = dec_sel_s;
          if (dec_hit_s) begin
            state_d   = ST_ACCESS;
            s_valid_d = sel_onehot_s;
`ifdef BUS_TIMEOUT_EN
            tmo_d     = '0;
`endif
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (done_s) begin
          state_d      = ST_RESP;
          s_valid_d    = '0;
          resp_valid_d = 1'b1;
          err_d        = 1'b0;
          rdata_d      = we_q ? '0 : slice_s;
`ifdef BUS_TIMEOUT_EN
        end else if (tmo_q == TMO_CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d      = ST_RESP;
          s_valid_d    = '0;
          resp_valid_d = 1'b1;
          err_d        = 1'b1;
          rdata_d      = '0;
        end else begin
          tmo_d = tmo_q + TMO_CNT_W'(1);
        end
`else
        end else begin
          state_d = ST_ACCESS;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        s_valid_d = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_valid_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      len_q        <= 3'b000;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      s_valid_q    <= s_valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      len_q        <= len_d;
      sel_q        <= sel_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign m_ready        = (state_q == ST_IDLE) && !reset;
  assign m_resp_valid   = resp_valid_q;
  assign m_read_data    = rdata_q;
  assign m_error        = err_q;
  assign s_valid        = s_valid_q;
  assign s_address      = addr_q;
  assign s_wr_data      = wdata_q;
  assign s_wr_enable    = we_q;
  assign s_write_length = len_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed cases plus randomized
// transactions checked against an address-rule reference model.
module tb_bus_interconnect;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            m_valid;
  logic            m_ready;
  logic [31:0]     m_address;
  logic [31:0]     m_wr_data;
  logic            m_wr_enable;
  logic [2:0]      m_write_length;
  logic            m_resp_valid;
  logic [31:0]     m_read_data;
  logic            m_error;
  logic [NS-1:0]   s_valid;
  logic [31:0]     s_address;
  logic [31:0]     s_wr_data;
  logic            s_wr_enable;
  logic [2:0]      s_write_length;
  logic [NS-1:0]   s_ready;
  logic [NS*DW-1:0] s_read_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;
  logic        last_err;

  always #5 clk = ~clk;

  bus_interconnect #(
    .ADDR_W(32), .DATA_W(DW), .NUM_SLAVES(NS), .SEL_W(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address),
    .m_wr_data(m_wr_data), .m_wr_enable(m_wr_enable), .m_write_length(m_write_length),
    .m_resp_valid(m_resp_valid), .m_read_data(m_read_data), .m_error(m_error),
    .s_valid(s_valid), .s_address(s_address), .s_wr_data(s_wr_data),
    .s_wr_enable(s_wr_enable), .s_write_length(s_write_length),
    .s_ready(s_ready), .s_read_data(s_read_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at posedge+1 of the cycle after acceptance
  task automatic start_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [2:0] len);
    @(posedge clk); #1;
    m_valid = 1'b1; m_address = a; m_wr_enable = we; m_wr_data = wd; m_write_length = len;
    @(negedge clk);
    chk("m_ready_idle", m_ready, 1);
    @(posedge clk); #1;
    m_valid = 1'b0; m_address = $urandom; m_wr_data = $urandom;
  endtask

  // Full transaction; the selected slave answers after 'delay' ACCESS cycles,
  // and a random other slave may raise s_ready meanwhile (must be ignored).
  task automatic run_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [2:0] len, input int delay);
    int sel;
    logic [31:0] slices [NS];
    logic [31:0] exp_rd;
    logic [NS-1:0] noise;
    sel = int'(a >> 28);
    start_req(a, we, wd, len);
    if (sel >= NS) begin
      @(negedge clk);
      chk("dec_resp_valid", m_resp_valid, 1);
      chk("dec_error", m_error, 1);
      chk("dec_rdata", m_read_data, 0);
      chk("dec_no_svalid", s_valid, 0);
      last_rd = 32'd0; last_err = 1'b1;
    end else begin
      exp_rd = 32'd0;
      for (int k = 0; k <= delay; k++) begin
        for (int j = 0; j < NS; j++) slices[j] = $urandom;
        for (int j = 0; j < NS; j++) s_read_data[j*DW +: DW] = slices[j];
        noise = NS'($urandom_range(0, (1 << NS) - 1));
        noise[sel] = 1'b0;
        s_ready = noise;
        if (k == delay) begin
          s_ready[sel] = 1'b1;
          exp_rd = we ? 32'd0 : slices[sel];
        end
        @(negedge clk);
        chk("s_valid_onehot", s_valid, 64'd1 << sel);
        chk("s_address", s_address, a);
        chk("s_wr_data", s_wr_data, wd);
        chk("s_wr_enable", s_wr_enable, we);
        chk("s_write_length", s_write_length, len);
        chk("no_early_resp", m_resp_valid, 0);
        chk("m_ready_busy", m_ready, 0);
        @(posedge clk); #1;
        s_ready = '0;
      end
      @(negedge clk);
      chk("resp_valid", m_resp_valid, 1);
      chk("resp_rdata", m_read_data, exp_rd);
      chk("resp_error", m_error, 0);
      chk("svalid_cleared", s_valid, 0);
      last_rd = exp_rd; last_err = 1'b0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_one_cycle", m_resp_valid, 0);
    chk("rdata_hold", m_read_data, last_rd);
    chk("error_hold", m_error, last_err);
    chk("back_to_idle", m_ready, 1);
  endtask

  initial begin
    int cnt;
    logic got;
    reset = 1'b1; m_valid = 1'b0; m_address = '0; m_wr_data = '0;
    m_wr_enable = 1'b0; m_write_length = 3'b000; s_ready = '0; s_read_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_resp_valid", m_resp_valid, 0);
    chk("rst_error", m_error, 0);
    chk("rst_rdata", m_read_data, 0);
    chk("rst_s_address", s_address, 0);
    chk("rst_s_wr_data", s_wr_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed: read slave1 immediate ready, write slave3, decode error
    start_req(32'h1000_0004, 1'b0, 32'h0, 3'b010);
    s_read_data = '0;
    s_read_data[1*DW +: DW] = 32'hDEAD_BEEF;
    s_ready = 4'b0010;
    @(negedge clk);
    chk("rd_s_valid_n1", s_valid, 4'b0010);
    @(posedge clk); #1;
    s_ready = '0;
    @(negedge clk);
    chk("rd_resp_n2", m_resp_valid, 1);
    chk("rd_data_beef", m_read_data, 32'hDEAD_BEEF);
    chk("rd_err0", m_error, 0);

    run_txn(32'h3000_0000, 1'b1, 32'h1234_5678, 3'b010, 0);
    run_txn(32'h5000_0000, 1'b0, 32'h0, 3'b000, 0);
    run_txn(32'h0000_0010, 1'b0, 32'h0, 3'b001, 3);
    run_txn(32'h2000_0000, 1'b0, 32'h0, 3'b010, TMO - 1);

    // Selected slave never ready
    start_req(32'h3000_0000, 1'b0, 32'h0, 3'b010);
    cnt = 0; got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      if (m_resp_valid) got = 1'b1;
      else if (s_valid == 4'b1000) cnt++;
      @(posedge clk); #1;
    end
`ifdef BUS_TIMEOUT_EN
    chk("tmo_resp", got, 1);
    chk("tmo_svalid_cycles", cnt, TMO);
    chk("tmo_error", m_error, 1);
    chk("tmo_rdata", m_read_data, 0);
`else
    chk("no_tmo_resp", got, 0);
    chk("no_tmo_svalid_held", cnt, 1000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    // Reset in the 3rd ACCESS cycle
    start_req(32'h2000_0008, 1'b0, 32'h0, 3'b010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst3_svalid_before", s_valid, 4'b0100);
    reset = 1'b1;
    #1;
    chk("rst3_svalid_async", s_valid, 0);
    chk("rst3_m_ready", m_ready, 0);
    chk("rst3_resp", m_resp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (m_resp_valid || (s_valid != '0)) got = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst3_no_resp", got, 0);
    chk("rst3_s_address", s_address, 0);
    run_txn(32'h1000_0100, 1'b0, 32'h0, 3'b010, 1);

    // Randomized transactions against the address-rule model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = {4'($urandom_range(0, 7)), 28'($urandom)};
      run_txn(a, 1'($urandom), $urandom, 3'($urandom_range(0, 2)), $urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter NUM_SLAVES, default 4, range 1..16, SHALL set the slave port count.
REQ-004 Parameter SEL_W, default 4, SHALL set the slave-select field width, taken from address[ADDR_W-1 -: SEL_W].
REQ-005 Parameter TIMEOUT_CYC, default 16, range 2..255, SHALL set the slave response timeout in cycles.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 m_valid  in  1  master request valid.
REQ-009 m_ready  out  1  request accepted this cycle.
REQ-010 m_address  in  ADDR_W  request address.
REQ-011 m_wr_data  in  DATA_W  write data.
REQ-012 m_wr_enable  in  1  1=write, 0=read.
REQ-013 m_write_length  in  3  access length code, passed through unchanged.
REQ-014 m_resp_valid  out  1  one-cycle response strobe.
REQ-015 m_read_data  out  DATA_W  read data; 0 for writes and errors.
REQ-016 m_error  out  1  decode error or timeout, qualified by m_resp_valid.
REQ-017 s_valid  out  NUM_SLAVES  one-hot request to the selected slave.
REQ-018 s_address, s_wr_data, s_wr_enable, s_write_length  out  ADDR_W/DATA_W/1/3  latched request, broadcast to all slaves.
REQ-019 s_ready  in  NUM_SLAVES  slave completion, one bit per slave.
REQ-020 s_read_data  in  NUM_SLAVES*DATA_W  slave i data in bits [i*DATA_W +: DATA_W].

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-022 m_ready SHALL be 1 only in IDLE with reset deasserted; a request is accepted when m_valid && m_ready.
REQ-023 On acceptance: all request fields latched; sel = select field; sel < NUM_SLAVES -> ACCESS, otherwise -> RESP with m_error=1.
REQ-024 In ACCESS, s_valid[sel] SHALL be 1 with all other bits 0, and the s_* fields SHALL hold stable.
REQ-025 In ACCESS, s_ready[sel]=1 SHALL capture s_read_data slice sel (reads only; writes capture 0), clear s_valid, and move to RESP; s_ready bits of other slaves SHALL be ignored.
REQ-026 RESP SHALL last exactly one cycle with m_resp_valid=1, then return to IDLE.
REQ-027 Minimum latency: accept at cycle N, s_valid at N+1, s_ready at N+1 -> m_resp_valid at N+2.
REQ-028 A decode error SHALL give m_resp_valid at N+1 with m_read_data=0 and no s_valid pulse.
REQ-029 m_read_data and m_error SHALL hold their values from the last response until the next response.

Reset
REQ-030 Reset SHALL force IDLE immediately, including mid-ACCESS, and SHALL discard the in-flight request without a response.
REQ-031 Reset values: s_valid=0, m_resp_valid=0, m_error=0, m_read_data=0, all s_* fields=0, timeout counter=0, m_ready=0 while reset is asserted.

Configuration
REQ-032 With BUS_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle.
REQ-033 With BUS_TIMEOUT_EN defined, reaching TIMEOUT_CYC ACCESS cycles without s_ready[sel] SHALL clear s_valid and go to RESP with m_error=1, m_read_data=0.
REQ-034 With BUS_TIMEOUT_EN defined, s_ready[sel] in the same cycle as expiry SHALL win, giving a normal response.
REQ-035 Without BUS_TIMEOUT_EN, no counter logic SHALL exist and ACCESS SHALL wait indefinitely.

Structure
REQ-036 Package bus_pkg SHALL hold the FSM state encoding, write-length codes (byte/half/word) and the timeout counter width.
REQ-037 Sub-module bus_addr_decoder SHALL be purely combinational: address -> sel index plus hit flag.
REQ-038 The datapath (slice mux, request latch) SHALL be parametric in NUM_SLAVES with no per-slave hand code.

Verification
REQ-039 Read 0x1000_0004 with slave1 s_ready at first s_valid cycle and data 0xDEADBEEF -> m_resp_valid at N+2, m_read_data=0xDEADBEEF, m_error=0.
REQ-040 Write 0x3000_0000, data 0x12345678, length 3'b010 -> s_valid=4'b1000, s_wr_data=0x12345678, s_write_length=3'b010; response read_data=0.
REQ-041 Access 0x5000_0000 with NUM_SLAVES=4 -> no s_valid pulse; m_resp_valid at N+1 with m_error=1.
REQ-042 BUS_TIMEOUT_EN, TIMEOUT_CYC=16, slave never ready -> s_valid held 16 cycles, then m_error=1; without the macro, no response after 1000 cycles.
REQ-043 Reset asserted in the 3rd ACCESS cycle -> s_valid=0 immediately, no m_resp_valid; the next request completes normally.
REQ-044 s_ready[2]=1 while sel=0 -> ignored; the transaction completes only on s_ready[0].
